mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single line-granular memory wrapper between the icache refill port (req 0) and the
//  dcache refill/writeback port (req 1). Round-robin grant, one outstanding transaction at a time.
//  Requests are registered before issue; responses are routed back to the granted requester only.
//  Sits between the caches and imem_wrapper; replaces the direct icache->wrapper connection.
// PARAMETERS
//  ADDR_W  32   byte address width of requests and responses
//  LINE_W  512  cache line width in bits
// PORTS
//  clk_i            in   1       clock, all state updates on rising edge
//  rstn_i           in   1       asynchronous active-low reset
//  ic_req_valid_i   in   1       icache line read request
//  ic_req_ready_o   out  1       arbiter accepts icache request this cycle
//  ic_addr_i        in   ADDR_W  icache line address
//  ic_rsp_valid_o   out  1       line response valid for icache
//  ic_rsp_ready_i   in   1       icache consumes response
//  ic_rsp_addr_o    out  ADDR_W  address of returned line
//  ic_line_o        out  LINE_W  returned line
//  dc_req_valid_i   in   1       dcache request (read or write)
//  dc_req_ready_o   out  1       arbiter accepts dcache request this cycle
//  dc_addr_i        in   ADDR_W  dcache line address
//  dc_we_i          in   1       1 = line write, 0 = line read
//  dc_wdata_i       in   LINE_W  write line data
//  dc_rsp_valid_o   out  1       response (read data or write ack) valid for dcache
//  dc_rsp_ready_i   in   1       dcache consumes response
//  dc_rsp_addr_o    out  ADDR_W  address of response
//  dc_line_o        out  LINE_W  returned line (don't-care for write ack)
//  mem_req_valid_o  out  1       request to memory wrapper
//  mem_req_ready_i  in   1       wrapper accepts request
//  mem_addr_o       out  ADDR_W  registered request address
//  mem_we_o         out  1       registered write enable
//  mem_wdata_o      out  LINE_W  registered write data
//  mem_rsp_valid_i  in   1       wrapper response valid
//  mem_rsp_ready_o  out  1       arbiter/requester accepts response
//  mem_rsp_addr_i   in   ADDR_W  response address
//  mem_line_i       in   LINE_W  response line
// BEHAVIOUR
//  - FSM IDLE -> ISSUE -> WAIT_RSP -> IDLE. Reset: state IDLE, last_grant=1 (icache wins first tie),
//    all valid/ready outputs 0, registered addr/wdata/we 0.
//  - IDLE: req_ready_o high only for the requester picked by round-robin among valid requests
//    (combinational on *_req_valid_i and last_grant). On accept: latch addr/we/wdata and grant id,
//    last_grant <= id, go ISSUE. No request: stay IDLE, both ready 0.
//  - Round-robin: both valid -> grant the one != last_grant; one valid -> grant it.
//  - ISSUE: mem_req_valid_o=1 with latched fields, held stable until mem_req_ready_i; then WAIT_RSP.
//    Earliest mem_req_valid_o is the cycle after requester accept (1-cycle issue latency).
//  - WAIT_RSP: mem_rsp_ready_o = granted requester's rsp_ready_i; granted *_rsp_valid_o =
//    mem_rsp_valid_i; rsp addr/line passed through combinationally. Non-granted rsp_valid_o = 0.
//    On mem_rsp_valid_i && mem_rsp_ready_o -> IDLE (new grant possible next cycle, not same cycle).
//  - Outside WAIT_RSP: mem_rsp_ready_o=0, both rsp_valid_o=0; stray wrapper responses stall, not lost.
//  - Writes (we=1) complete on the wrapper's ack response exactly like reads.
//  - Requester dropping req_valid while not accepted: no effect; after accept, the request is owned
//    by the arbiter regardless of later requester inputs.
//  - Back-to-back: same requester re-requesting while the other waits loses the next arbitration.
//  - Reset mid-transaction: immediate return to IDLE, in-flight request abandoned (wrapper shares rstn_i).
// STRUCTURE
//  - tartaruga_pkg: mem_req_t {addr, we, wdata}, arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RSP},
//    localparam LINE_W=512.
//  - Sub-module rr_arb2: 2-way round-robin pick (req[1:0], last_grant -> gnt[1:0]), combinational.
//  - Single always_ff for state/latched request/last_grant; always_comb for outputs and routing.
// TESTING
//  1. Reset: rstn_i=0 mid-ISSUE -> all valid/ready outputs 0 same cycle, IDLE after release.
//  2. ic only, addr 0x40, wrapper ready=1, rsp after 3 cycles -> mem_req_valid_o at cycle 1,
//     ic_rsp_valid_o with addr 0x40 and line; dc_rsp_valid_o stays 0.
//  3. ic and dc valid same cycle from reset -> ic granted first (addr 0x00), dc (0x80) next; both
//     persistently valid -> grants alternate ic,dc,ic,dc.
//  4. dc write addr 0x100 wdata pattern A5.. -> mem_we_o=1, mem_wdata_o=pattern held until ready;
//     ack returns on dc_rsp_valid_o only.
//  5. mem_req_ready_i low 5 cycles -> mem_addr_o/mem_we_o/mem_wdata_o stable, no new grant.
//  6. Granted rsp_ready low 4 cycles while mem_rsp_valid_i high -> mem_rsp_ready_o low; completes on
//     first ready cycle, next grant no earlier than the following cycle.

Source files
------------

// File: rtl/tartaruga_pkg.sv
// ============================================================================
// tartaruga_pkg : shared types and widths for the memory arbiter  (rev 1.0)
// ============================================================================
`default_nettype none

package tartaruga_pkg;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 512;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [LINE_W-1:0] wdata;
   } mem_req_t;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_ISSUE    = 2'd1,
      ARB_WAIT_RSP = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : combinational 2-way round-robin pick                   (rev 1.0)
// ============================================================================
`default_nettype none

module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   output logic [1:0] o_gnt
);

   // A tie goes to the requester that did not win last time.
   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = i_last_grant ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin sharing of the line memory wrapper between
//               icache (id 0) and dcache (id 1), one transaction in flight.
//               rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 512
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              ic_req_valid_i,
   output logic              ic_req_ready_o,
   input  logic [ADDR_W-1:0] ic_addr_i,
   output logic              ic_rsp_valid_o,
   input  logic              ic_rsp_ready_i,
   output logic [ADDR_W-1:0] ic_rsp_addr_o,
   output logic [LINE_W-1:0] ic_line_o,
   input  logic              dc_req_valid_i,
   output logic              dc_req_ready_o,
   input  logic [ADDR_W-1:0] dc_addr_i,
   input  logic              dc_we_i,
   input  logic [LINE_W-1:0] dc_wdata_i,
   output logic              dc_rsp_valid_o,
   input  logic              dc_rsp_ready_i,
   output logic [ADDR_W-1:0] dc_rsp_addr_o,
   output logic [LINE_W-1:0] dc_line_o,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic              mem_rsp_valid_i,
   output logic              mem_rsp_ready_o,
   input  logic [ADDR_W-1:0] mem_rsp_addr_i,
   input  logic [LINE_W-1:0] mem_line_i
);

   import tartaruga_pkg::arb_state_t;
   import tartaruga_pkg::ARB_IDLE;
   import tartaruga_pkg::ARB_ISSUE;
   import tartaruga_pkg::ARB_WAIT_RSP;

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              r_gnt_id;
   logic              r_last_grant;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [LINE_W-1:0] r_wdata;
   logic [1:0]        w_gnt;
   logic              w_accept;
   logic              w_rsp_ready;

   rr_arb2 u_rr_arb2 (
      .i_req        ({dc_req_valid_i, ic_req_valid_i}),
      .i_last_grant (r_last_grant),
      .o_gnt        (w_gnt)
   );

   // Gating with rstn_i keeps the ready outputs low while reset is asserted.
   assign w_accept = (r_state == ARB_IDLE) && rstn_i && (|w_gnt);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state      <= ARB_IDLE;
         r_gnt_id     <= 1'b0;
         r_last_grant <= 1'b1;
         r_addr       <= '0;
         r_we         <= 1'b0;
         r_wdata      <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_gnt_id     <= w_gnt[1];
            r_last_grant <= w_gnt[1];
            r_addr       <= w_gnt[1] ? dc_addr_i : ic_addr_i;
            r_we         <= w_gnt[1] & dc_we_i;
            r_wdata      <= w_gnt[1] ? dc_wdata_i : '0;
         end
      end
   end

   assign mem_addr_o    = r_addr;
   assign mem_we_o      = r_we;
   assign mem_wdata_o   = r_wdata;
   assign ic_rsp_addr_o = mem_rsp_addr_i;
   assign ic_line_o     = mem_line_i;
   assign dc_rsp_addr_o = mem_rsp_addr_i;
   assign dc_line_o     = mem_line_i;
   assign w_rsp_ready   = r_gnt_id ? dc_rsp_ready_i : ic_rsp_ready_i;

   always_comb begin
      w_state_nxt     = r_state;
      ic_req_ready_o  = 1'b0;
      dc_req_ready_o  = 1'b0;
      mem_req_valid_o = 1'b0;
      mem_rsp_ready_o = 1'b0;
      ic_rsp_valid_o  = 1'b0;
      dc_rsp_valid_o  = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            ic_req_ready_o = rstn_i & w_gnt[0];
            dc_req_ready_o = rstn_i & w_gnt[1];
            if (w_accept) w_state_nxt = ARB_ISSUE;
         end
         ARB_ISSUE: begin
            mem_req_valid_o = 1'b1;
            if (mem_req_ready_i) w_state_nxt = ARB_WAIT_RSP;
         end
         ARB_WAIT_RSP: begin
            // Responses only flow to the owner; the other port never sees them.
            mem_rsp_ready_o = w_rsp_ready;
            ic_rsp_valid_o  = ~r_gnt_id & mem_rsp_valid_i;
            dc_rsp_valid_o  = r_gnt_id & mem_rsp_valid_i;
            if (mem_rsp_valid_i && w_rsp_ready) w_state_nxt = ARB_IDLE;
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : scoreboard bench for mem_arbiter with a wrapper model
//                  rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

   logic         clk_i = 1'b0;
   logic         rstn_i;
   logic         ic_req_valid_i, ic_req_ready_o, ic_rsp_valid_o, ic_rsp_ready_i;
   logic [31:0]  ic_addr_i, ic_rsp_addr_o;
   logic [511:0] ic_line_o;
   logic         dc_req_valid_i, dc_req_ready_o, dc_we_i, dc_rsp_valid_o, dc_rsp_ready_i;
   logic [31:0]  dc_addr_i, dc_rsp_addr_o;
   logic [511:0] dc_wdata_i, dc_line_o;
   logic         mem_req_valid_o, mem_req_ready_i, mem_we_o, mem_rsp_valid_i, mem_rsp_ready_o;
   logic [31:0]  mem_addr_o, mem_rsp_addr_i;
   logic [511:0] mem_wdata_o, mem_line_i;

   typedef struct {
      logic         id;
      logic [31:0]  addr;
      logic         we;
      logic [511:0] wdata;
   } exp_t;

   exp_t sb_mem[$];
   exp_t sb_rsp[$];
   logic grant_log[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   rsp_cyc = 0;
   int   cfg_req_stall = 0;
   int   cfg_rsp_delay = 0;

   mem_arbiter #(.ADDR_W(32), .LINE_W(512)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o), .ic_addr_i(ic_addr_i),
      .ic_rsp_valid_o(ic_rsp_valid_o), .ic_rsp_ready_i(ic_rsp_ready_i),
      .ic_rsp_addr_o(ic_rsp_addr_o), .ic_line_o(ic_line_o),
      .dc_req_valid_i(dc_req_valid_i), .dc_req_ready_o(dc_req_ready_o), .dc_addr_i(dc_addr_i),
      .dc_we_i(dc_we_i), .dc_wdata_i(dc_wdata_i),
      .dc_rsp_valid_o(dc_rsp_valid_o), .dc_rsp_ready_i(dc_rsp_ready_i),
      .dc_rsp_addr_o(dc_rsp_addr_o), .dc_line_o(dc_line_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
      .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
      .mem_rsp_addr_i(mem_rsp_addr_i), .mem_line_i(mem_line_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] line_of(input logic [31:0] a);
      return {16{a ^ 32'hC0DE_0000}};
   endfunction

   // Scoreboard: requests enter on acceptance, leave on issue and on response.
   always @(negedge clk_i) begin
      exp_t e;
      if (!rstn_i) begin
         sb_mem.delete();
         sb_rsp.delete();
      end else begin
         if (ic_req_ready_o && dc_req_ready_o) chk("dual_ready", dc_req_ready_o, 1'b0);
         if (ic_req_valid_i && ic_req_ready_o) begin
            e = '{1'b0, ic_addr_i, 1'b0, '0};
            sb_mem.push_back(e); sb_rsp.push_back(e); grant_log.push_back(1'b0); acc_cyc = cyc;
         end
         if (dc_req_valid_i && dc_req_ready_o) begin
            e = '{1'b1, dc_addr_i, dc_we_i, dc_wdata_i};
            sb_mem.push_back(e); sb_rsp.push_back(e); grant_log.push_back(1'b1); acc_cyc = cyc;
         end
         if (mem_req_valid_o && mem_req_ready_i) begin
            chk("mem_sb_depth", sb_mem.size(), 1);
            if (sb_mem.size() > 0) begin
               e = sb_mem.pop_front();
               chk("mem_addr", mem_addr_o, e.addr);
               chk("mem_we", mem_we_o, e.we);
               if (e.we) chk("mem_wdata", mem_wdata_o, e.wdata);
            end
         end
         if (ic_rsp_valid_o || dc_rsp_valid_o) chk("rsp_exclusive", ic_rsp_valid_o & dc_rsp_valid_o, 1'b0);
         if (ic_rsp_valid_o && ic_rsp_ready_i) begin
            chk("ic_rsp_depth", sb_rsp.size(), 1);
            rsp_cyc = cyc;
            if (sb_rsp.size() > 0) begin
               e = sb_rsp.pop_front();
               chk("ic_rsp_owner", 1'b0, e.id);
               chk("ic_rsp_addr", ic_rsp_addr_o, e.addr);
               chk("ic_line", ic_line_o, line_of(e.addr));
            end
         end
         if (dc_rsp_valid_o && dc_rsp_ready_i) begin
            chk("dc_rsp_depth", sb_rsp.size(), 1);
            rsp_cyc = cyc;
            if (sb_rsp.size() > 0) begin
               e = sb_rsp.pop_front();
               chk("dc_rsp_owner", 1'b1, e.id);
               chk("dc_rsp_addr", dc_rsp_addr_o, e.addr);
               if (!e.we) chk("dc_line", dc_line_o, line_of(e.addr));
            end
         end
      end
   end

   // Memory wrapper model: optional request stall, then a delayed response.
   initial begin : wrapper_model
      logic        req_hs, rsp_hs, busy;
      int          cnt, dly;
      logic [31:0] cap_addr;
      mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
      mem_rsp_addr_i = '0; mem_line_i = '0;
      busy = 1'b0; cnt = 0; dly = 0; cap_addr = '0;
      forever begin
         @(negedge clk_i);
         req_hs = mem_req_valid_o && mem_req_ready_i;
         rsp_hs = mem_rsp_valid_i && mem_rsp_ready_o;
         if (req_hs) cap_addr = mem_addr_o;
         @(posedge clk_i); #1;
         if (!rstn_i) begin
            mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
            busy = 1'b0; cnt = 0; dly = 0;
         end else if (!busy) begin
            if (req_hs) begin
               busy = 1'b1; mem_req_ready_i = 1'b0; cnt = 0; dly = 0;
            end else if (mem_req_valid_o) begin
               if (cnt < cfg_req_stall) begin
                  cnt++; mem_req_ready_i = 1'b0;
               end else begin
                  mem_req_ready_i = 1'b1;
               end
            end else begin
               mem_req_ready_i = 1'b0;
            end
         end else begin
            if (rsp_hs) begin
               busy = 1'b0; mem_rsp_valid_i = 1'b0;
            end else if (!mem_rsp_valid_i) begin
               if (dly >= cfg_rsp_delay) begin
                  mem_rsp_valid_i = 1'b1; mem_rsp_addr_i = cap_addr; mem_line_i = line_of(cap_addr);
               end else begin
                  dly++;
               end
            end
         end
      end
   end

   task automatic do_reset();
      rstn_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rstn_i = 1'b1;
   endtask

   task automatic ic_req(input logic [31:0] a);
      logic got = 1'b0;
      ic_req_valid_i = 1'b1; ic_addr_i = a;
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clk_i);
         got = ic_req_ready_o;
         @(posedge clk_i); #1;
      end
      ic_req_valid_i = 1'b0;
      chk("ic_accept", got, 1'b1);
   endtask

   task automatic dc_req(input logic we, input logic [31:0] a, input logic [511:0] d);
      logic got = 1'b0;
      dc_req_valid_i = 1'b1; dc_addr_i = a; dc_we_i = we; dc_wdata_i = d;
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clk_i);
         got = dc_req_ready_o;
         @(posedge clk_i); #1;
      end
      dc_req_valid_i = 1'b0;
      chk("dc_accept", got, 1'b1);
   endtask

   task automatic wait_done();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk_i);
         if (sb_rsp.size() == 0) break;
      end
      chk("done_timeout", sb_rsp.size(), 0);
      @(posedge clk_i); #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : main
      logic         exp_order[4];
      logic [511:0] wpat;
      logic         got;
      ic_req_valid_i = 1'b0; ic_addr_i = '0; ic_rsp_ready_i = 1'b1;
      dc_req_valid_i = 1'b0; dc_addr_i = '0; dc_we_i = 1'b0; dc_wdata_i = '0; dc_rsp_ready_i = 1'b1;
      rstn_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("rst_ic_ready", ic_req_ready_o, 1'b0);
      chk("rst_dc_ready", dc_req_ready_o, 1'b0);
      chk("rst_mem_valid", mem_req_valid_o, 1'b0);
      chk("rst_mem_rsp_ready", mem_rsp_ready_o, 1'b0);
      chk("rst_rsp_valids", {ic_rsp_valid_o, dc_rsp_valid_o}, 2'b00);
      chk("rst_mem_fields", {mem_addr_o, mem_we_o, mem_wdata_o}, '0);
      do_reset();

      // Single icache read, 1-cycle issue latency
      cfg_rsp_delay = 3;
      ic_req(32'h40);
      @(negedge clk_i);
      chk("issue_lat", mem_req_valid_o, 1'b1);
      wait_done();

      // Simultaneous requests from reset, then alternation
      do_reset();
      cfg_rsp_delay = 1;
      grant_log.delete();
      fork
         begin ic_req(32'h00); ic_req(32'h40); end
         begin dc_req(1'b0, 32'h80, '0); dc_req(1'b0, 32'hC0, '0); end
      join
      wait_done();
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
      chk("rr_count", grant_log.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < grant_log.size()) chk($sformatf("rr_order_%0d", i), grant_log[i], exp_order[i]);

      // dcache line write, stalled briefly by the wrapper
      cfg_req_stall = 3;
      wpat = {64{8'hA5}};
      dc_req(1'b1, 32'h100, wpat);
      wait_done();

      // Wrapper not ready for 5 cycles: fields stable, no new grant
      cfg_req_stall = 5;
      wpat = {64{8'h3C}};
      dc_req(1'b1, 32'h140, wpat);
      ic_req_valid_i = 1'b1; ic_addr_i = 32'h240;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("stall_valid", {mem_req_valid_o, mem_req_ready_i}, 2'b10);
         chk("stall_addr", mem_addr_o, 32'h140);
         chk("stall_we", mem_we_o, 1'b1);
         chk("stall_wdata", mem_wdata_o, wpat);
         chk("stall_no_grant", ic_req_ready_o, 1'b0);
         @(posedge clk_i); #1;
      end
      ic_req(32'h240);
      wait_done();

      // Granted requester back-pressures the response for 4 cycles
      cfg_req_stall = 0;
      cfg_rsp_delay = 1;
      ic_rsp_ready_i = 1'b0;
      ic_req(32'h300);
      fork
         dc_req(1'b0, 32'h380, '0);
         begin
            got = 1'b0;
            for (int n = 0; n < 50 && !got; n++) begin
               @(negedge clk_i);
               got = mem_rsp_valid_i;
               if (!got) begin @(posedge clk_i); #1; end
            end
            chk("rsp_seen", got, 1'b1);
            for (int i = 0; i < 4; i++) begin
               if (i > 0) @(negedge clk_i);
               chk("bp_mem_rsp_ready", mem_rsp_ready_o, 1'b0);
               chk("bp_ic_rsp_valid", ic_rsp_valid_o, 1'b1);
               chk("bp_no_grant", dc_req_ready_o, 1'b0);
               @(posedge clk_i); #1;
            end
            ic_rsp_ready_i = 1'b1;
         end
      join
      chk("regrant_gap", acc_cyc - rsp_cyc, 1);
      wait_done();

      // Reset while the wrapper is still refusing the request
      cfg_req_stall = 10;
      ic_req(32'h500);
      @(negedge clk_i);
      chk("pre_rst_issue", mem_req_valid_o, 1'b1);
      @(posedge clk_i); #1;
      dc_req_valid_i = 1'b1; dc_addr_i = 32'h580; dc_we_i = 1'b0;
      rstn_i = 1'b0;
      #1;
      chk("midrst_mem_valid", mem_req_valid_o, 1'b0);
      chk("midrst_readies", {ic_req_ready_o, dc_req_ready_o, mem_rsp_ready_o}, 3'b000);
      chk("midrst_rsp_valids", {ic_rsp_valid_o, dc_rsp_valid_o}, 2'b00);
      dc_req_valid_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rstn_i = 1'b1;
      @(negedge clk_i);
      chk("postrst_idle", mem_req_valid_o, 1'b0);
      chk("postrst_addr", mem_addr_o, 32'h0);
      @(posedge clk_i); #1;
      cfg_req_stall = 0;
      ic_req(32'h540);
      wait_done();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
